// File: rtl/instr_mem_responder.sv
// Instruction-fetch memory responder: grants word fetches, inserts WAIT_CYCLES
// wait states, then returns one registered instruction word with an error flag.
module instr_mem_responder #(
    parameter int unsigned DEPTH       = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned WAIT_CYCLES = 0,
    parameter logic [31:0] ERR_RDATA   = 32'h0000_0013,
    localparam int unsigned IDX_W      = $clog2(DEPTH)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             instr_req_i,
    input  logic [31:0]      instr_addr_i,
    output logic             instr_gnt_o,
    output logic             instr_rvalid_o,
    output logic [31:0]      instr_rdata_o,
    output logic             instr_err_o,
    input  logic             load_we_i,
    input  logic [IDX_W-1:0] load_addr_i,
    input  logic [31:0]      load_wdata_i
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

    state_e           state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             fetch_err_q, fetch_err_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             err_q, err_d;

    logic [31:0]      mem [DEPTH];

    logic [31:0]      offset;
    logic [31:0]      word_idx;
    logic [IDX_W-1:0] req_idx;
    logic             req_err;
    logic             gnt;
    logic             resp_load;
    logic [IDX_W-1:0] rd_idx;
    logic             rd_err;

    // Subtraction wraps, so addresses below BASE_ADDR land far out of range.
    assign offset   = instr_addr_i - BASE_ADDR;
    assign word_idx = {2'b00, offset[31:2]};
    assign req_idx  = word_idx[IDX_W-1:0];
    assign req_err  = (offset[1:0] != 2'b00) || (word_idx >= 32'(DEPTH));

    assign gnt = rst_ni && ((state_q == IDLE) || (state_q == RESP))
                 && instr_req_i && !load_we_i;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        fetch_err_d = fetch_err_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        resp_load   = 1'b0;
        rd_idx      = req_idx;
        rd_err      = req_err;

        case (state_q)
            IDLE, RESP: begin
                if (gnt) begin
                    idx_d       = req_idx;
                    fetch_err_d = req_err;
                    if (WAIT_CYCLES > 0) begin
                        state_d = WAIT;
                        cnt_d   = WAIT_INIT;
                    end else begin
                        state_d   = RESP;
                        resp_load = 1'b1;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            WAIT: begin
                cnt_d  = cnt_q - 4'd1;
                rd_idx = idx_q;
                rd_err = fetch_err_q;
                if (cnt_q == 4'd1) begin
                    state_d   = RESP;
                    resp_load = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Read happens before any same-edge load write lands, so old data is returned.
        if (resp_load) begin
            rdata_d = rd_err ? ERR_RDATA : mem[rd_idx];
            err_d   = rd_err;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            idx_q       <= '0;
            fetch_err_q <= 1'b0;
            rdata_q     <= 32'h0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            fetch_err_q <= fetch_err_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (load_we_i) begin
            mem[load_addr_i] <= load_wdata_i;
        end
    end

    assign instr_gnt_o    = gnt;
    assign instr_rvalid_o = (state_q == RESP);
    assign instr_rdata_o  = rdata_q;
    assign instr_err_o    = err_q;

endmodule

// File: tb/tb_instr_mem_responder.sv
// Directed bench for instr_mem_responder: three instances with WAIT_CYCLES 0, 3, 2
// sharing one load port; table-driven zero-wait checks plus multi-cycle sequences.
module tb_instr_mem_responder;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n [3];
    logic        req   [3];
    logic [31:0] addr  [3];
    logic        gnt   [3];
    logic        rvalid[3];
    logic [31:0] rdata [3];
    logic        err   [3];

    logic        load_we;
    logic [3:0]  load_addr;
    logic [31:0] load_wdata;

    int checks = 0;
    int errors = 0;

    instr_mem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(0)) u_w0 (
        .clk_i(clk), .rst_ni(rst_n[0]), .instr_req_i(req[0]), .instr_addr_i(addr[0]),
        .instr_gnt_o(gnt[0]), .instr_rvalid_o(rvalid[0]), .instr_rdata_o(rdata[0]),
        .instr_err_o(err[0]), .load_we_i(load_we), .load_addr_i(load_addr),
        .load_wdata_i(load_wdata));

    instr_mem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(3)) u_w3 (
        .clk_i(clk), .rst_ni(rst_n[1]), .instr_req_i(req[1]), .instr_addr_i(addr[1]),
        .instr_gnt_o(gnt[1]), .instr_rvalid_o(rvalid[1]), .instr_rdata_o(rdata[1]),
        .instr_err_o(err[1]), .load_we_i(load_we), .load_addr_i(load_addr),
        .load_wdata_i(load_wdata));

    instr_mem_responder #(.DEPTH(DEPTH), .WAIT_CYCLES(2)) u_w2 (
        .clk_i(clk), .rst_ni(rst_n[2]), .instr_req_i(req[2]), .instr_addr_i(addr[2]),
        .instr_gnt_o(gnt[2]), .instr_rvalid_o(rvalid[2]), .instr_rdata_o(rdata[2]),
        .instr_err_o(err[2]), .load_we_i(load_we), .load_addr_i(load_addr),
        .load_wdata_i(load_wdata));

    typedef struct {
        logic        req;
        logic [31:0] addr;
        logic        we;
        logic [3:0]  la;
        logic [31:0] wd;
        logic        gnt;
        logic        rv;
        logic [31:0] rdata;
        logic        err;
    } vec_t;

    vec_t vecs [14];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Advance to the next falling edge, drive instance k, let combinational outputs settle.
    task automatic drive(input int k, input logic r, input logic [31:0] a);
        @(negedge clk);
        req[k]  = r;
        addr[k] = a;
        #1;
    endtask

    task automatic chk_resp(input string nm, input int k, input logic rv,
                            input logic [31:0] rd, input logic e);
        chk({nm, " rvalid"}, 32'(rvalid[k]), 32'(rv));
        chk({nm, " rdata"}, rdata[k], rd);
        chk({nm, " err"}, 32'(err[k]), 32'(e));
        $display("%s: k=%0d gnt=%b rvalid=%b rdata=%h err=%b", nm, k, gnt[k], rvalid[k], rdata[k], err[k]);
    endtask

    // Grant, then WAIT cycles with rvalid low, then the response cycle checked.
    task automatic fetch_wait(input string nm, input int k, input int w,
                              input logic [31:0] a, input logic [31:0] exp_rd, input logic exp_e);
        drive(k, 1'b1, a);
        chk({nm, " gnt"}, 32'(gnt[k]), 32'd1);
        for (int i = 0; i < w; i++) begin
            drive(k, 1'b0, a);
            chk($sformatf("%s wait%0d rvalid", nm, i), 32'(rvalid[k]), 32'd0);
        end
        drive(k, 1'b0, a);
        chk_resp({nm, " resp"}, k, 1'b1, exp_rd, exp_e);
    endtask

    initial begin
        logic [3:0]  pre_a [5];
        logic [31:0] pre_d [5];
        pre_a = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd7};
        pre_d = '{32'h11, 32'h22, 32'h33, 32'h44, 32'h77};

        //            req   addr          we    la    wd            gnt   rv    rdata         err
        vecs[0]  = '{1'b1, 32'h0000_0000, 1'b0, 4'd0, 32'h0,        1'b1, 1'b0, 32'h0,        1'b0};
        vecs[1]  = '{1'b1, 32'h0000_0004, 1'b0, 4'd0, 32'h0,        1'b1, 1'b1, 32'h11,       1'b0};
        vecs[2]  = '{1'b1, 32'h0000_0008, 1'b0, 4'd0, 32'h0,        1'b1, 1'b1, 32'h22,       1'b0};
        vecs[3]  = '{1'b1, 32'h0000_000C, 1'b0, 4'd0, 32'h0,        1'b1, 1'b1, 32'h33,       1'b0};
        vecs[4]  = '{1'b0, 32'h0000_0000, 1'b0, 4'd0, 32'h0,        1'b0, 1'b1, 32'h44,       1'b0};
        vecs[5]  = '{1'b0, 32'h0000_0000, 1'b0, 4'd0, 32'h0,        1'b0, 1'b0, 32'h44,       1'b0};
        vecs[6]  = '{1'b1, 32'h0000_0002, 1'b0, 4'd0, 32'h0,        1'b1, 1'b0, 32'h44,       1'b0};
        vecs[7]  = '{1'b1, 32'h0000_0040, 1'b0, 4'd0, 32'h0,        1'b1, 1'b1, 32'h13,       1'b1};
        vecs[8]  = '{1'b1, 32'hFFFF_FFFC, 1'b0, 4'd0, 32'h0,        1'b1, 1'b1, 32'h13,       1'b1};
        vecs[9]  = '{1'b0, 32'h0000_0000, 1'b0, 4'd0, 32'h0,        1'b0, 1'b1, 32'h13,       1'b1};
        vecs[10] = '{1'b1, 32'h0000_0018, 1'b1, 4'd6, 32'hABCD_1234, 1'b0, 1'b0, 32'h13,      1'b1};
        vecs[11] = '{1'b1, 32'h0000_0018, 1'b0, 4'd0, 32'h0,        1'b1, 1'b0, 32'h13,       1'b1};
        vecs[12] = '{1'b0, 32'h0000_0000, 1'b0, 4'd0, 32'h0,        1'b0, 1'b1, 32'hABCD_1234, 1'b0};
        vecs[13] = '{1'b0, 32'h0000_0000, 1'b0, 4'd0, 32'h0,        1'b0, 1'b0, 32'hABCD_1234, 1'b0};

        for (int k = 0; k < 3; k++) begin
            rst_n[k] = 1'b0;
            req[k]   = 1'b0;
            addr[k]  = 32'h0;
        end
        load_we    = 1'b0;
        load_addr  = 4'd0;
        load_wdata = 32'h0;

        // Reset state, with a live request to show the grant is held off.
        req[0] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("reset%0d gnt", k), 32'(gnt[k]), 32'd0);
            chk_resp($sformatf("reset%0d", k), k, 1'b0, 32'h0, 1'b0);
        end
        @(negedge clk);
        req[0] = 1'b0;
        for (int k = 0; k < 3; k++) rst_n[k] = 1'b1;

        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            load_we    = 1'b1;
            load_addr  = pre_a[i];
            load_wdata = pre_d[i];
        end
        @(negedge clk);
        load_we = 1'b0;

        // Zero-wait instance: back-to-back fetches, errors, load priority.
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            req[0]     = vecs[i].req;
            addr[0]    = vecs[i].addr;
            load_we    = vecs[i].we;
            load_addr  = vecs[i].la;
            load_wdata = vecs[i].wd;
            #1;
            chk($sformatf("vec%0d gnt", i), 32'(gnt[0]), 32'(vecs[i].gnt));
            chk_resp($sformatf("vec%0d", i), 0, vecs[i].rv, vecs[i].rdata, vecs[i].err);
        end
        @(negedge clk);
        load_we = 1'b0;
        req[0]  = 1'b0;

        // Three-wait instance: requests ignored while waiting, deassert does not cancel.
        drive(1, 1'b1, 32'h4);
        chk("w3a gnt", 32'(gnt[1]), 32'd1);
        for (int i = 1; i <= 3; i++) begin
            drive(1, (i < 3), 32'h4);
            chk($sformatf("w3a wait%0d gnt", i), 32'(gnt[1]), 32'd0);
            chk($sformatf("w3a wait%0d rvalid", i), 32'(rvalid[1]), 32'd0);
        end
        drive(1, 1'b0, 32'h4);
        chk_resp("w3a resp", 1, 1'b1, 32'h22, 1'b0);

        // Response data holds while idle.
        fetch_wait("w3b", 1, 3, 32'h8, 32'h33, 1'b0);
        for (int i = 0; i < 5; i++) begin
            drive(1, 1'b0, 32'h0);
            chk_resp($sformatf("w3b hold%0d", i), 1, 1'b0, 32'h33, 1'b0);
        end

        // Load to the same word on the edge that enters RESP returns the old data.
        drive(1, 1'b1, 32'h1C);
        chk("w3c gnt", 32'(gnt[1]), 32'd1);
        drive(1, 1'b0, 32'h1C);
        drive(1, 1'b0, 32'h1C);
        drive(1, 1'b0, 32'h1C);
        load_we    = 1'b1;
        load_addr  = 4'd7;
        load_wdata = 32'h99;
        drive(1, 1'b0, 32'h1C);
        load_we = 1'b0;
        chk_resp("w3c resp", 1, 1'b1, 32'h77, 1'b0);
        fetch_wait("w3d", 1, 3, 32'h1C, 32'h99, 1'b0);

        // Two-wait instance: back-to-back grant in RESP, then reset aborts it.
        fetch_wait("w2a", 2, 2, 32'hC, 32'h44, 1'b0);
        req[2]  = 1'b1;
        addr[2] = 32'h8;
        #1;
        chk("w2b gnt", 32'(gnt[2]), 32'd1);
        @(negedge clk);
        rst_n[2] = 1'b0;
        #1;
        chk("w2 rst gnt", 32'(gnt[2]), 32'd0);
        chk_resp("w2 rst", 2, 1'b0, 32'h0, 1'b0);
        @(negedge clk);
        rst_n[2] = 1'b1;
        req[2]   = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            chk_resp($sformatf("w2 post%0d", i), 2, 1'b0, 32'h0, 1'b0);
            drive(2, 1'b0, 32'h0);
        end
        fetch_wait("w2c", 2, 2, 32'h4, 32'h22, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
